// File: rtl/ex_div_seq_if.sv
// Request/response bundle between the EX stage and the sequential divider.
interface ex_div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, funct3, SrcA, SrcB, flush,
    input  busy, stall, done, Result
  );

  modport slave (
    input  start, funct3, SrcA, SrcB, flush,
    output busy, stall, done, Result
  );
endinterface

// File: rtl/ex_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU in the EX stage.
// Divide-by-zero and signed overflow are resolved at accept and skip the
// iteration entirely.
module ex_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_div_seq_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic            rem_op_q, rem_op_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            accept;
  logic            in_sgn;
  logic            in_rem;
  logic [XLEN:0]   shift;
  logic [XLEN:0]   diff;

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
    end
  end

  // Next-state, restoring-division step and sign fix-up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;

    // 100 DIV and 110 REM are signed; only 110/111 select the remainder.
    in_sgn = bus.funct3[2] & ~bus.funct3[0];
    in_rem = bus.funct3[2] &  bus.funct3[1];
    accept = (state_q == IDLE) && bus.start && !bus.flush;

    // 33-bit trial subtract keeps the carry of the shifted remainder.
    shift = {rem_q, quo_q[XLEN-1]};
    diff  = shift - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = bus.SrcA;
          b_d      = bus.SrcB;
          sgn_d    = in_sgn;
          rem_op_d = in_rem;
          if (bus.SrcB == '0) begin
            res_d   = in_rem ? bus.SrcA : '1;
            state_d = DONE;
          end else if (in_sgn && bus.SrcA == MIN_NEG && bus.SrcB == '1) begin
            res_d   = in_rem ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          quo_d     = (sgn_q && a_q[XLEN-1]) ? -a_q : a_q;
          dvs_d     = (sgn_q && b_q[XLEN-1]) ? -b_q : b_q;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          neg_rem_d = sgn_q & a_q[XLEN-1];
          state_d   = ITER;
        end
      end
      ITER: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(XLEN-1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (rem_op_q) res_d = neg_rem_q ? -rem_q : rem_q;
          else          res_d = neg_quo_q ? -quo_q : quo_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs; stall drops in DONE so the instruction retires.
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.stall  = accept || (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign bus.Result = res_q;

endmodule
